lsb_embedder_mc: RTL and testbench

//  Parametrised multi-channel LSB steganography embedder; successor to the single-channel bit changer.

---
 rtl/stego_pkg.sv | 21 ++
 rtl/msg_bit_source.sv | 60 ++++++
 rtl/lsb_embedder_mc.sv | 103 ++++++++++
 tb/tb_lsb_embedder_mc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/stego_pkg.sv
// Shared definitions for the multi-channel LSB embedder.
//   state_e    : embedder FSM states
//   ch_width   : width of a channel index (at least 1 bit)
//   ptr_width  : width of the message bit pointer (must hold 0..MSG_LEN)
package stego_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMBED = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int ptr_width(input int msg_len);
    return $clog2(msg_len + 1);
  endfunction

endpackage

// File: rtl/msg_bit_source.sv
// Message store and bit pointer for the LSB embedder.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (message and pointer to 0)
//   load_i     : latch message_i and restart at its first bit
//   message_i  : message, bit MSG_LEN-1 is sent first
//   advance_i  : consume the current chunk
//   chunk_o    : next EMBED_BITS message bits, first-sent bit in the MSB,
//                zero-padded past the end of the message
//   last_o     : current chunk contains the final message bit
module msg_bit_source import stego_pkg::*; #(
  parameter  int MSG_LEN    = 88,
  parameter  int EMBED_BITS = 1,
  localparam int PTR_W      = ptr_width(MSG_LEN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [MSG_LEN-1:0]    message_i,
  input  logic                  advance_i,
  output logic [EMBED_BITS-1:0] chunk_o,
  output logic                  last_o
);

  logic [MSG_LEN-1:0]            msg_q;
  logic [PTR_W-1:0]              ptr_q;
  logic [PTR_W-1:0]              ptr_d;
  logic [PTR_W:0]                ptr_sum;
  logic [MSG_LEN+EMBED_BITS-1:0] window;

  // Shifting the message left by the pointer brings the next unsent bit to
  // the top; the appended zeros provide the tail padding for a short chunk.
  assign window  = {msg_q, {EMBED_BITS{1'b0}}} << ptr_q;
  assign chunk_o = window[MSG_LEN+EMBED_BITS-1 -: EMBED_BITS];

  assign ptr_sum = {1'b0, ptr_q} + (PTR_W+1)'(EMBED_BITS);
  assign last_o  = (ptr_sum >= (PTR_W+1)'(MSG_LEN));

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = '0;
    end else if (advance_i) begin
      ptr_d = last_o ? '0 : ptr_sum[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msg_q <= '0;
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load_i) begin
        msg_q <= message_i;
      end
    end
  end

endmodule

// File: rtl/lsb_embedder_mc.sv
// Multi-channel LSB steganography embedder.
// Replaces the EMBED_BITS LSBs of samples on enabled channels with message
// bits; everything else passes through. One-cycle latency, no back-pressure.
// Ports:
//   in_clk, in_reset      : clock, synchronous active-high reset
//   in_enable             : sample strobe
//   in_frame, in_channel  : sample and its channel index
//   in_channel_mask       : bit c enables embedding on channel c
//   in_msg_load           : latch in_message and (re)start embedding
//   in_message            : message, MSB sent first
//   out_frame/out_channel : registered sample and channel
//   out_ready             : output valid strobe
//   out_embedded          : output sample carries message bits
//   out_msg_done          : output sample carries the final message bit
//   out_busy              : FSM is in EMBED
module lsb_embedder_mc import stego_pkg::*; #(
  parameter  int BPS        = 24,
  parameter  int CHANNELS   = 2,
  parameter  int EMBED_BITS = 1,
  parameter  int MSG_LEN    = 88,
  parameter  int MSG_REPEAT = 1,
  localparam int CH_W       = ch_width(CHANNELS)
) (
  input  logic                in_clk,
  input  logic                in_reset,
  input  logic                in_enable,
  input  logic [BPS-1:0]      in_frame,
  input  logic [CH_W-1:0]     in_channel,
  input  logic [CHANNELS-1:0] in_channel_mask,
  input  logic                in_msg_load,
  input  logic [MSG_LEN-1:0]  in_message,
  output logic [BPS-1:0]      out_frame,
  output logic [CH_W-1:0]     out_channel,
  output logic                out_ready,
  output logic                out_embedded,
  output logic                out_msg_done,
  output logic                out_busy
);

  localparam int MASK_W = 1 << CH_W;

  state_e                  state_q;
  state_e                  state_d;
  logic [MASK_W-1:0]       mask_ext;
  logic                    chan_hit;
  logic                    embed_now;
  logic [EMBED_BITS-1:0]   chunk;
  logic                    last;

  // Zero-extending the mask to every encodable channel index makes indices
  // at or above CHANNELS read as masked without a separate range check.
  assign mask_ext  = MASK_W'(in_channel_mask);
  assign chan_hit  = mask_ext[in_channel];

  // A coincident load takes priority: that sample passes through untouched.
  assign embed_now = (state_q == EMBED) && in_enable && !in_msg_load && chan_hit;

  msg_bit_source #(
    .MSG_LEN    (MSG_LEN),
    .EMBED_BITS (EMBED_BITS)
  ) u_src (
    .clk_i     (in_clk),
    .rst_i     (in_reset),
    .load_i    (in_msg_load),
    .message_i (in_message),
    .advance_i (embed_now),
    .chunk_o   (chunk),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    if (in_msg_load) begin
      state_d = EMBED;
    end else if (embed_now && last && (MSG_REPEAT == 0)) begin
      state_d = DONE;
    end
  end

  // Output register stage
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q      <= IDLE;
      out_frame    <= '0;
      out_channel  <= '0;
      out_ready    <= 1'b0;
      out_embedded <= 1'b0;
      out_msg_done <= 1'b0;
      out_busy     <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_busy     <= (state_d == EMBED);
      out_ready    <= in_enable;
      out_embedded <= embed_now;
      out_msg_done <= embed_now && last;
      if (in_enable) begin
        out_channel <= in_channel;
        out_frame   <= embed_now ? {in_frame[BPS-1:EMBED_BITS], chunk} : in_frame;
      end
    end
  end

endmodule

// File: tb/tb_lsb_embedder_mc.sv
module tb_lsb_embedder_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] frame;
  logic        ch;
  logic [1:0]  mask;
  logic        load;
  logic [87:0] msg88;
  logic [7:0]  msg8;

  // dut_a: defaults (EMBED_BITS=1, MSG_LEN=88, repeat)
  logic [23:0] a_frame; logic a_ch, a_rdy, a_emb, a_done, a_busy;
  // dut_b: EMBED_BITS=3, MSG_LEN=8, repeat
  logic [23:0] b_frame; logic b_ch, b_rdy, b_emb, b_done, b_busy;
  // dut_c: EMBED_BITS=1, MSG_LEN=8, no repeat
  logic [23:0] c_frame; logic c_ch, c_rdy, c_emb, c_done, c_busy;

  int checks = 0;
  int errors = 0;

  localparam logic [87:0] MSG_A5  = {11{8'hA5}};
  localparam logic [7:0]  MSG_D6  = 8'b1101_0110;

  always #5 clk = ~clk;

  lsb_embedder_mc dut_a (
    .in_clk(clk), .in_reset(rst), .in_enable(en), .in_frame(frame), .in_channel(ch),
    .in_channel_mask(mask), .in_msg_load(load), .in_message(msg88),
    .out_frame(a_frame), .out_channel(a_ch), .out_ready(a_rdy), .out_embedded(a_emb),
    .out_msg_done(a_done), .out_busy(a_busy)
  );

  lsb_embedder_mc #(.EMBED_BITS(3), .MSG_LEN(8), .MSG_REPEAT(1)) dut_b (
    .in_clk(clk), .in_reset(rst), .in_enable(en), .in_frame(frame), .in_channel(ch),
    .in_channel_mask(mask), .in_msg_load(load), .in_message(msg8),
    .out_frame(b_frame), .out_channel(b_ch), .out_ready(b_rdy), .out_embedded(b_emb),
    .out_msg_done(b_done), .out_busy(b_busy)
  );

  lsb_embedder_mc #(.EMBED_BITS(1), .MSG_LEN(8), .MSG_REPEAT(0)) dut_c (
    .in_clk(clk), .in_reset(rst), .in_enable(en), .in_frame(frame), .in_channel(ch),
    .in_channel_mask(mask), .in_msg_load(load), .in_message(msg8),
    .out_frame(c_frame), .out_channel(c_ch), .out_ready(c_rdy), .out_embedded(c_emb),
    .out_msg_done(c_done), .out_busy(c_busy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One sample strobe; outputs are observed 1 time unit after the edge.
  task automatic send(input logic [23:0] f, input logic c, input logic [1:0] m);
    frame = f; ch = c; mask = m; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (a_frame !== 24'h0) begin errors++; $display("FAIL reset_frame: got %h want 000000", a_frame); end
    checks++; if ({a_rdy, a_emb, a_done, a_busy, a_ch} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {a_rdy, a_emb, a_done, a_busy, a_ch}); end
    checks++; if ({b_busy, c_busy, b_rdy, c_rdy} !== 4'b0) begin errors++; $display("FAIL reset_bc: got %b want 0000", {b_busy, c_busy, b_rdy, c_rdy}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_embed_basic();
    logic [23:0] exp;
    msg88 = MSG_A5; msg8 = MSG_D6;
    do_load();
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", a_busy); end
    for (int i = 0; i < 4; i++) begin
      exp = {23'h7FFFFF, MSG_A5[87-i]};
      send(24'hFFFFFF, 1'(i % 2), 2'b11);
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d]: got %b want 1", i, a_rdy); end
      checks++; if (a_frame !== exp) begin errors++; $display("FAIL basic_frame[%0d]: got %h want %h", i, a_frame, exp); end
      checks++; if (a_emb !== 1'b1 || a_ch !== 1'(i % 2)) begin errors++; $display("FAIL basic_emb_ch[%0d]: got %b%b want 1%b", i, a_emb, a_ch, 1'(i % 2)); end
    end
    tick();
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %b want 0", a_rdy); end
  endtask

  // Continues from pointer 4 of the message loaded in test_embed_basic.
  task automatic test_mask();
    logic [23:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 0) ? {23'h0, MSG_A5[87-4-i/2]} : 24'h0;
      send(24'h000000, 1'(i % 2), 2'b01);
      checks++; if (a_frame !== exp) begin errors++; $display("FAIL mask_frame[%0d]: got %h want %h", i, a_frame, exp); end
      checks++; if (a_emb !== (i % 2 == 0)) begin errors++; $display("FAIL mask_emb[%0d]: got %b want %b", i, a_emb, (i % 2 == 0)); end
    end
    // Pointer must now be at 8 (bit 79 = 1).
    send(24'h000000, 1'b1, 2'b11);
    checks++; if (a_frame !== 24'h000001) begin errors++; $display("FAIL mask_ptr: got %h want 000001", a_frame); end
  endtask

  task automatic test_multibit_tail();
    logic [23:0] exp [4] = '{24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC, 24'hFFFFFE};
    logic        dn  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    msg8 = MSG_D6;
    do_load();
    for (int i = 0; i < 4; i++) begin
      send(24'hFFFFFF, 1'b0, 2'b11);
      checks++; if (b_frame !== exp[i]) begin errors++; $display("FAIL tail_frame[%0d]: got %h want %h", i, b_frame, exp[i]); end
      checks++; if (b_done !== dn[i]) begin errors++; $display("FAIL tail_done[%0d]: got %b want %b", i, b_done, dn[i]); end
    end
  endtask

  task automatic test_repeat_modes();
    logic [23:0] exp;
    msg88 = MSG_A5; msg8 = MSG_D6;
    do_load();
    for (int i = 0; i < 90; i++) begin
      send(24'h123456, 1'b0, 2'b11);
      if (i < 8) begin
        exp = {24'h123456 | {23'h0, MSG_D6[7-i]}};
        checks++; if (c_frame !== exp || c_emb !== 1'b1) begin errors++; $display("FAIL norep_frame[%0d]: got %h/%b want %h/1", i, c_frame, c_emb, exp); end
        checks++; if (c_done !== (i == 7)) begin errors++; $display("FAIL norep_done[%0d]: got %b want %b", i, c_done, (i == 7)); end
      end else if (i < 10) begin
        checks++; if (c_frame !== 24'h123456 || c_emb !== 1'b0 || c_rdy !== 1'b1) begin errors++; $display("FAIL norep_pass[%0d]: got %h/%b/%b want 123456/0/1", i, c_frame, c_emb, c_rdy); end
        checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL norep_busy[%0d]: got %b want 0", i, c_busy); end
      end
      if (i >= 86) begin
        exp = {24'h123456 | {23'h0, MSG_A5[87-(i % 88)]}};
        checks++; if (a_frame !== exp) begin errors++; $display("FAIL rep_frame[%0d]: got %h want %h", i, a_frame, exp); end
        checks++; if (a_done !== (i == 87) || a_busy !== 1'b1) begin errors++; $display("FAIL rep_done_busy[%0d]: got %b%b want %b1", i, a_done, a_busy, (i == 87)); end
      end
    end
  endtask

  // dut_a is mid-message (pointer 2) on entry.
  task automatic test_load_coincident();
    msg88 = 88'h40_0000_0000_0000_0000_0000;
    load = 1'b1;
    send(24'hFFFFFE, 1'b0, 2'b11);
    load = 1'b0;
    checks++; if (a_frame !== 24'hFFFFFE || a_emb !== 1'b0 || a_rdy !== 1'b1) begin errors++; $display("FAIL coload_pass: got %h/%b/%b want fffffe/0/1", a_frame, a_emb, a_rdy); end
    checks++; if (a_done !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL coload_ctrl: got %b%b want 01", a_done, a_busy); end
    send(24'hFFFFFF, 1'b0, 2'b11);
    checks++; if (a_frame !== 24'hFFFFFE || a_emb !== 1'b1) begin errors++; $display("FAIL coload_first: got %h/%b want fffffe/1", a_frame, a_emb); end
    send(24'hFFFFFE, 1'b0, 2'b11);
    checks++; if (a_frame !== 24'hFFFFFF) begin errors++; $display("FAIL coload_second: got %h want ffffff", a_frame); end
  endtask

  task automatic test_reset_mid();
    frame = 24'hFFFFFF; ch = 1'b1; mask = 2'b11; en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    checks++; if (a_frame !== 24'h0 || {a_rdy, a_emb, a_done, a_busy, a_ch} !== 5'b0) begin errors++; $display("FAIL rstmid_out: got %h/%b want 000000/00000", a_frame, {a_rdy, a_emb, a_done, a_busy, a_ch}); end
    send(24'h123457, 1'b1, 2'b11);
    checks++; if (a_frame !== 24'h123457 || a_emb !== 1'b0 || a_busy !== 1'b0 || a_rdy !== 1'b1 || a_ch !== 1'b1) begin errors++; $display("FAIL rstmid_pass: got %h/%b%b%b%b want 123457/0011", a_frame, a_emb, a_busy, a_rdy, a_ch); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; frame = '0; ch = 1'b0; mask = 2'b00; load = 1'b0;
    msg88 = '0; msg8 = '0;
    test_reset();
    test_embed_basic();
    test_mask();
    test_multibit_tail();
    test_repeat_modes();
    test_load_coincident();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
